// File: rtl/otter_intr_ctrl.sv
// otter_intr_ctrl: multi-source interrupt controller driving the OTTER CU FSM intr input.
// Optional feature: define OTTER_INTC_LEVEL_EN for level-sensitive sources (default: rising-edge latched).
module otter_intr_ctrl #(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               RST,
    input  logic [NUM_SRC-1:0] irq_src,
    // int_taken / mret_exec are single-cycle strobes from the CU FSM; there is no
    // back-pressure: int_taken is accepted only while intr=1, mret_exec always.
    input  logic               int_taken,
    input  logic               mret_exec,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic               intr,
    output logic [4:0]         irq_id
);
    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_SWTRIG  = 2'd3;

    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] r_sync;
    logic [NUM_SRC-1:0]                  r_enable;
    logic                                r_busy;
    logic [4:0]                          r_irq_id;

    logic [NUM_SRC-1:0] w_s;
    logic [NUM_SRC-1:0] w_pending;
    logic [NUM_SRC-1:0] w_active;
    logic [NUM_SRC-1:0] w_w1c;
    logic [NUM_SRC-1:0] w_swset;
    logic [NUM_SRC-1:0] w_take_mask;
    logic [NUM_SRC-1:0] w_clr;
    logic [4:0]         w_sel;
    logic               w_take;
    logic               w_unused;

    assign w_unused = &{1'b0, cfg_wdata};

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= irq_src;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_s     = r_sync[SYNC_STAGES-1];
    assign w_w1c   = (cfg_we && cfg_addr == ADDR_PENDING) ? cfg_wdata[NUM_SRC-1:0] : '0;
    assign w_swset = (cfg_we && cfg_addr == ADDR_SWTRIG)  ? cfg_wdata[NUM_SRC-1:0] : '0;
    assign w_clr   = w_w1c | w_take_mask;

`ifdef OTTER_INTC_LEVEL_EN
    // Only software-triggered requests are stored; hardware requests follow the synchronised level.
    logic [NUM_SRC-1:0] r_swpend;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_swpend <= '0;
        end else begin
            r_swpend <= (r_swpend & ~w_clr) | w_swset;
        end
    end

    assign w_pending = w_s | r_swpend;
`else
    logic [NUM_SRC-1:0] r_s_d;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] w_rise;

    assign w_rise = w_s & ~r_s_d;

    // Set terms are OR-ed after the clear so a new request always survives a same-cycle clear.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_s_d     <= '0;
            r_pending <= '0;
        end else begin
            r_s_d     <= w_s;
            r_pending <= (r_pending & ~w_clr) | w_rise | w_swset;
        end
    end

    assign w_pending = r_pending;
`endif

    assign w_active = w_pending & r_enable;
    assign intr     = (|w_active) & ~r_busy;
    assign w_take   = int_taken & intr;

    always_comb begin
        w_sel = 5'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_sel = 5'(i);
            end
        end
    end

    always_comb begin
        w_take_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_take_mask[i] = w_take && (w_sel == 5'(i));
        end
    end

    // A take in the same cycle as mret_exec wins: the new interrupt goes in service.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_enable <= '0;
            r_busy   <= 1'b0;
            r_irq_id <= 5'd0;
        end else begin
            if (cfg_we && cfg_addr == ADDR_ENABLE) begin
                r_enable <= cfg_wdata[NUM_SRC-1:0];
            end
            if (w_take) begin
                r_busy   <= 1'b1;
                r_irq_id <= w_sel;
            end else if (mret_exec) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign irq_id = r_irq_id;

    always_comb begin
        cfg_rdata = 32'd0;
        case (cfg_addr)
            ADDR_ENABLE:  cfg_rdata = 32'(r_enable);
            ADDR_PENDING: cfg_rdata = 32'(w_pending);
            ADDR_STATUS:  cfg_rdata = {r_busy, 26'd0, r_irq_id};
            ADDR_SWTRIG:  cfg_rdata = 32'd0;
            default:      cfg_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// tb_otter_intr_ctrl: scoreboard bench for otter_intr_ctrl (edge mode by default, level mode with OTTER_INTC_LEVEL_EN).
module tb_otter_intr_ctrl;
    localparam int NUM_SRC = 8;
    localparam logic [1:0] A_EN = 2'd0;
    localparam logic [1:0] A_PEND = 2'd1;
    localparam logic [1:0] A_STAT = 2'd2;
    localparam logic [1:0] A_SW = 2'd3;

    logic               clk;
    logic               RST;
    logic [NUM_SRC-1:0] irq_src;
    logic               int_taken;
    logic               mret_exec;
    logic               cfg_we;
    logic [1:0]         cfg_addr;
    logic [31:0]        cfg_wdata;
    logic [31:0]        cfg_rdata;
    logic               intr;
    logic [4:0]         irq_id;

    logic [31:0] exp_q[$];
    int n_cmp;
    int n_err;

    otter_intr_ctrl #(.NUM_SRC(NUM_SRC), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .RST       (RST),
        .irq_src   (irq_src),
        .int_taken (int_taken),
        .mret_exec (mret_exec),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .intr      (intr),
        .irq_id    (irq_id)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish (observed timeout, required completion)");
        $fatal(1, "watchdog");
    end

    // checking
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic observe(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check_val(tag, obs, e);
    endtask

    // driver tasks: inputs change just after the falling edge, outputs sampled there too
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = d;
        step(1);
        cfg_we = 1'b0;
        cfg_wdata = $urandom();
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] e);
        expect_val(e);
        cfg_addr = a;
        #1;
        observe(tag, cfg_rdata);
    endtask

    task automatic chk_intr(input string tag, input logic e);
        expect_val({31'd0, e});
        observe(tag, {31'd0, intr});
    endtask

    task automatic take();
        int_taken = 1'b1;
        step(1);
        int_taken = 1'b0;
    endtask

    task automatic mret();
        mret_exec = 1'b1;
        step(1);
        mret_exec = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        RST = 1'b1;
        irq_src = '0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        cfg_we = 1'b0;
        cfg_addr = A_EN;
        cfg_wdata = 32'd0;
        step(3);
        RST = 1'b0;
        step(1);

        // reset state
        chk_intr("rst_intr", 1'b0);
        chk_reg("rst_enable", A_EN, 32'h0);
        chk_reg("rst_pending", A_PEND, 32'h0);
        chk_reg("rst_status", A_STAT, 32'h0);
        expect_val(32'h0);
        observe("rst_irq_id", {27'd0, irq_id});

        // fixed priority via software trigger
        write_reg(A_EN, 32'hFF);
        write_reg(A_SW, 32'h84);
        chk_intr("prio_intr", 1'b1);
        chk_reg("prio_pending", A_PEND, 32'h84);
        take();
        chk_reg("prio_status2", A_STAT, 32'h8000_0002);
        chk_reg("prio_pending_after", A_PEND, 32'h80);
        chk_intr("prio_busy_intr", 1'b0);
        mret();
        chk_intr("prio_refire", 1'b1);
        take();
        chk_reg("prio_status7", A_STAT, 32'h8000_0007);
        expect_val(32'd7);
        observe("prio_irq_id_port", {27'd0, irq_id});
        mret();
        chk_intr("prio_idle", 1'b0);
        chk_reg("prio_status_hold", A_STAT, 32'h0000_0007);

        // int_taken and mret_exec together: take wins
        write_reg(A_EN, 32'h10);
        write_reg(A_SW, 32'h10);
        int_taken = 1'b1;
        mret_exec = 1'b1;
        step(1);
        int_taken = 1'b0;
        mret_exec = 1'b0;
        chk_reg("both_status", A_STAT, 32'h8000_0004);
        chk_reg("both_pending", A_PEND, 32'h0);
        mret();
        chk_reg("mret_status", A_STAT, 32'h0000_0004);
        take();
        chk_reg("take_idle_ignored", A_STAT, 32'h0000_0004);

        // register boundaries
        write_reg(A_EN, 32'hFFFF_FFFF);
        chk_reg("enable_upper", A_EN, 32'h0000_00FF);
        write_reg(A_SW, 32'hFFFF_FF00);
        chk_reg("swtrig_upper", A_PEND, 32'h0);
        chk_intr("swtrig_upper_intr", 1'b0);
        write_reg(A_STAT, 32'hFFFF_FFFF);
        chk_reg("status_ro", A_STAT, 32'h0000_0004);
        chk_reg("swtrig_reads0", A_SW, 32'h0);

`ifdef OTTER_INTC_LEVEL_EN
        // level-sensitive source re-fires after mret while still asserted
        write_reg(A_EN, 32'h10);
        irq_src[4] = 1'b1;
        expect_val(32'd0);
        expect_val(32'd1);
        step(1);
        observe("lvl_lat1", {31'd0, intr});
        step(1);
        observe("lvl_lat2", {31'd0, intr});
        take();
        chk_intr("lvl_busy", 1'b0);
        chk_reg("lvl_status", A_STAT, 32'h8000_0004);
        mret();
        chk_intr("lvl_refire", 1'b1);
        write_reg(A_PEND, 32'h10);
        chk_reg("lvl_w1c_no_effect", A_PEND, 32'h10);
        take();
        irq_src[4] = 1'b0;
        step(2);
        mret();
        chk_intr("lvl_released", 1'b0);
        chk_reg("lvl_pending_clear", A_PEND, 32'h0);
`else
        // latency: source 0 rising edge -> intr after exactly 3 edges
        write_reg(A_EN, 32'h01);
        irq_src[0] = 1'b1;
        expect_val(32'd0);
        expect_val(32'd0);
        expect_val(32'd1);
        for (int e = 1; e <= 3; e++) begin
            step(1);
            observe($sformatf("lat_edge%0d", e), {31'd0, intr});
        end
        take();
        chk_intr("lat_taken_intr", 1'b0);
        chk_reg("lat_status", A_STAT, 32'h8000_0000);
        mret();
        chk_intr("lat_held_no_refire", 1'b0);
        chk_reg("lat_status_after", A_STAT, 32'h0);
        irq_src[0] = 1'b0;
        step(3);

        // collision: rise beats W1C on the same edge
        write_reg(A_EN, 32'h0);
        write_reg(A_SW, 32'h08);
        irq_src[3] = 1'b1;
        step(2);
        write_reg(A_PEND, 32'h08);
        chk_reg("collide_pending", A_PEND, 32'h08);
        write_reg(A_PEND, 32'h08);
        chk_reg("w1c_pending", A_PEND, 32'h0);
        irq_src[3] = 1'b0;
        step(3);

        // mask: disabled source stays pending, fires on enable
        irq_src[1] = 1'b1;
        step(1);
        irq_src[1] = 1'b0;
        step(3);
        chk_reg("mask_pending", A_PEND, 32'h02);
        chk_intr("mask_intr", 1'b0);
        write_reg(A_EN, 32'h02);
        chk_intr("mask_enabled_intr", 1'b1);
        take();
        chk_reg("mask_status", A_STAT, 32'h8000_0001);
        mret();
`endif

        // asynchronous reset mid-operation
        write_reg(A_EN, 32'h05);
        write_reg(A_SW, 32'h05);
        take();
        write_reg(A_SW, 32'h01);
        chk_reg("pre_rst_pending", A_PEND, 32'h05);
        chk_reg("pre_rst_status", A_STAT, 32'h8000_0000);
        #2;
        RST = 1'b1;
        #1;
        chk_intr("async_rst_intr", 1'b0);
        chk_reg("async_rst_enable", A_EN, 32'h0);
        chk_reg("async_rst_pending", A_PEND, 32'h0);
        chk_reg("async_rst_status", A_STAT, 32'h0);
        step(2);
        RST = 1'b0;
        step(1);
        chk_intr("post_rst_intr", 1'b0);

        check_val("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
